nn_param_regs: RTL and testbench
================================

// Module: nn_param_regs
// PURPOSE
//  Parametrised memory-mapped register bank for the 2-layer NN accelerator: N_IN operands, N_HID
//  hidden neurons (L1 weights/biases, L2 weights/bias), CTRL/STATUS and a RES_DEPTH result FIFO.
//  Sits between the bus-side decoder and the NN datapath; issues start, tracks busy, raises irq.
// PARAMETERS
//  DATA_W     32            register/data width
//  BASE_ADDR  32'h3000_0000 byte base; reg k at BASE_ADDR + 4*k
//  N_IN       2             operands (= inputs per hidden neuron)
//  N_HID      2             hidden neurons
//  RES_DEPTH  4             result FIFO depth, power of 2, >=2
// PORTS
//  clk      in   1                  clock, rising edge
//  rst_l    in   1                  async active-low reset
//  addr     in   32                 byte address
//  wren     in   1                  write request, 1-cycle pulse
//  rden     in   1                  read request, 1-cycle pulse
//  wrdata   in   DATA_W             write data
//  ack      out  1                  access complete, 1 cycle after request
//  err      out  1                  access rejected, valid with ack
//  rddata   out  DATA_W             read data, valid with ack
//  ops      out  N_IN*DATA_W        operands, op k at [k*DATA_W +: DATA_W]
//  w_l1     out  N_HID*N_IN*DATA_W  L1 weights, index h*N_IN+i
//  b_l1     out  N_HID*DATA_W       L1 biases
//  w_l2     out  N_HID*DATA_W       L2 weights
//  b_l2     out  DATA_W             L2 bias
//  start    out  1                  1-cycle inference start pulse
//  ready    in   1                  NN_result valid, 1-cycle pulse
//  NN_result in  DATA_W             datapath result
//  irq      out  1                  registered: irq_en & FIFO non-empty
// BEHAVIOUR
//  Map (word idx): 0..N_IN-1 OPS | C=N_IN CTRL | C+1 STATUS(RO) | C+2 RESULT(RO, pop) |
//   then w_l1 (N_HID*N_IN), b_l1 (N_HID), w_l2 (N_HID), b_l2 (1). LAST = C+3+N_HID*(N_IN+2).
//  CTRL: b0 START (W1, self-clear, reads 0), b1 IRQ_EN (RW), b2 FIFO_CLR (W1, reads 0).
//  STATUS: b0 busy, b1 empty, b2 full, b3 overflow (sticky, W1C via write to STATUS b3),
//   [15:8] FIFO count; other bits 0. STATUS writes affect only b3.
//  Reset: all regs, outputs, count, pointers, busy, overflow, irq_en = 0; empty=1.
//  Access: request sampled at edge N; ack=1 at N+1 for exactly 1 cycle, rddata/err with it.
//   rddata=0 on writes and errors. wren&rden same cycle -> write only.
//  err=1, no state change: addr[1:0]!=0, outside BASE..LAST, write to RESULT, read-empty RESULT,
//   START while busy, OPS/weight write while busy (when NN_REGS_SHADOW_EN off).
//  START: at edge N+1 start=1 for one cycle, busy=1; busy clears on edge sampling ready.
//   start and ready same cycle: busy stays 1 (new run). ready while !busy still pushes.
//  FIFO: ready pushes NN_result; full -> drop, overflow=1. Push+pop same cycle when full:
//   both happen, no overflow; when empty: pop errs, push happens. FIFO_CLR beats same-cycle push.
//  Pointers wrap mod RES_DEPTH; count 0..RES_DEPTH.
//  Reset mid-run: busy, FIFO and all registers return to reset values immediately.
// CONFIGURATION
//  NN_REGS_SHADOW_EN defined: OPS/weight/bias writes land in shadow regs (always accepted,
//   also while busy); readback returns shadow; all shadows copy to outputs on the edge that
//   raises start, so outputs are frozen during a run.
//  Undefined: writes update outputs at the ack edge; such writes while busy are rejected (err).
// TESTING
//  1 reset, read STATUS -> ack 1 cycle later, rddata=32'h0000_0002, irq=0, start=0
//  2 write 0x3000_0000=32'h1234_5678, 0x3000_0004=32'h8765_4321 -> ops=64'h87654321_12345678,
//    readback matches, err=0
//  3 write CTRL=32'h3, ready with NN_result=32'hDEAD_BEEF -> start pulse 1 cycle, busy 1->0,
//    irq=1, read RESULT=32'hDEAD_BEEF, then irq=0, STATUS count=0
//  4 5 ready pulses (1..5) w/o pop -> STATUS=32'h0000_040C (count 4, full, overflow),
//    pops return 1,2,3,4, 5th pop err=1 rddata=0; write STATUS b3 -> overflow=0
//  5 addr 0x3000_0002, 0x3000_0100, write RESULT, START while busy -> each err=1, no state change
//  6 while busy write w_l1[0]=32'hA5 -> off: err=1, w_l1 unchanged; SHADOW_EN: err=0,
//    w_l1[0] unchanged until next start, then 32'hA5

Source files
------------

// File: rtl/nn_param_regs.sv
// -----------------------------------------------------------------------------
// nn_param_regs
//   Memory-mapped register bank for the 2-layer NN accelerator. It holds the
//   operands, the L1/L2 weights and biases, CTRL/STATUS and a small result
//   FIFO. It issues the inference start pulse, tracks busy and raises irq.
//
//   Word map (index k lives at BASE_ADDR + 4*k, C = N_IN):
//     0..C-1  OPS           C    CTRL         C+1  STATUS (RO)
//     C+2     RESULT (RO, read pops the FIFO)
//     C+3..   w_l1 (N_HID*N_IN), b_l1 (N_HID), w_l2 (N_HID), b_l2 (1)
//
//   Optional feature macro: NN_REGS_SHADOW_EN
//     defined   : parameter writes land in shadow registers and are accepted
//                 while busy; the shadows are copied to the outputs on the
//                 edge that raises start.
//     undefined : parameter writes drive the outputs directly and are
//                 rejected (err) while busy.
//
// Ports
//   clk, rst_l           clock (rising edge), asynchronous active-low reset
//   addr, wren, rden,    bus request (1-cycle pulses); wren wins over rden
//   wrdata
//   ack, err, rddata     registered response one cycle after the request
//   ops, w_l1, b_l1,     parameter outputs to the datapath
//   w_l2, b_l2
//   start                1-cycle inference start pulse
//   ready, NN_result     datapath result strobe and value
//   irq                  registered irq_en & FIFO non-empty
// -----------------------------------------------------------------------------
module nn_param_regs #(
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          N_IN      = 2,
    parameter int          N_HID     = 2,
    parameter int          RES_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic [31:0]                   addr,
    input  logic                          wren,
    input  logic                          rden,
    input  logic [DATA_W-1:0]             wrdata,
    output logic                          ack,
    output logic                          err,
    output logic [DATA_W-1:0]             rddata,
    output logic [N_IN*DATA_W-1:0]        ops,
    output logic [N_HID*N_IN*DATA_W-1:0]  w_l1,
    output logic [N_HID*DATA_W-1:0]       b_l1,
    output logic [N_HID*DATA_W-1:0]       w_l2,
    output logic [DATA_W-1:0]             b_l2,
    output logic                          start,
    input  logic                          ready,
    input  logic [DATA_W-1:0]             NN_result,
    output logic                          irq
);

    localparam int IDX_CTRL   = N_IN;
    localparam int IDX_STATUS = N_IN + 1;
    localparam int IDX_RESULT = N_IN + 2;
    localparam int IDX_W0     = N_IN + 3;
    localparam int N_WT       = N_HID * (N_IN + 2) + 1;
    localparam int LAST       = IDX_W0 + N_WT - 1;
    localparam int N_PARAM    = N_IN + N_WT;
    localparam int PIDX_W     = $clog2(N_PARAM);
    localparam int PTR_W      = $clog2(RES_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    // Offsets of each group inside the flat parameter array
    localparam int P_WL1 = N_IN;
    localparam int P_BL1 = P_WL1 + N_HID * N_IN;
    localparam int P_WL2 = P_BL1 + N_HID;
    localparam int P_BL2 = P_WL2 + N_HID;

    // ---------------- state ----------------
    logic              ack_reg, err_reg, start_reg, busy_reg, irq_reg;
    logic              irq_en_reg, ovf_reg;
    logic [DATA_W-1:0] rddata_reg;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [DATA_W-1:0] fifo_mem [RES_DEPTH];

    logic [DATA_W-1:0] param_view [N_PARAM];   // value returned on readback
    logic [DATA_W-1:0] param_out  [N_PARAM];   // value driven to the datapath

    // ---------------- address decode ----------------
    logic [31:0]       word_idx;
    logic              in_range, is_ops, is_wt, is_param;
    logic [PIDX_W-1:0] param_idx;

    assign word_idx  = (addr - BASE_ADDR) >> 2;
    assign in_range  = (addr >= BASE_ADDR) && (word_idx <= 32'(LAST));
    assign is_ops    = word_idx < 32'(N_IN);
    assign is_wt     = word_idx >= 32'(IDX_W0);
    assign is_param  = is_ops || is_wt;
    // Weights follow the operands directly in the flat array, skipping
    // the three control words.
    assign param_idx = PIDX_W'(is_ops ? word_idx : word_idx - 32'(IDX_W0 - N_IN));

    // ---------------- FIFO status ----------------
    logic fifo_empty, fifo_full;
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(RES_DEPTH));

    logic [DATA_W-1:0] status_val;
    always_comb begin
        status_val       = '0;
        status_val[0]    = busy_reg;
        status_val[1]    = fifo_empty;
        status_val[2]    = fifo_full;
        status_val[3]    = ovf_reg;
        status_val[15:8] = 8'(count_reg);
    end

    // ---------------- access decode ----------------
    logic              wr_req, rd_req;
    logic              acc_err, param_wr, start_fire, irq_en_wr, fifo_clr;
    logic              ovf_clr, pop;
    logic [DATA_W-1:0] rd_val;

    assign wr_req = wren;
    assign rd_req = rden && !wren;

    always_comb begin
        acc_err    = 1'b0;
        param_wr   = 1'b0;
        start_fire = 1'b0;
        irq_en_wr  = 1'b0;
        fifo_clr   = 1'b0;
        ovf_clr    = 1'b0;
        pop        = 1'b0;
        rd_val     = '0;
        if (wr_req || rd_req) begin
            if (addr[1:0] != 2'b00 || !in_range) begin
                acc_err = 1'b1;
            end else if (wr_req) begin
                if (is_param) begin
`ifdef NN_REGS_SHADOW_EN
                    param_wr = 1'b1;
`else
                    if (busy_reg) acc_err  = 1'b1;
                    else          param_wr = 1'b1;
`endif
                end else if (word_idx == 32'(IDX_CTRL)) begin
                    // A rejected START rejects the whole CTRL write
                    if (wrdata[0] && busy_reg) begin
                        acc_err = 1'b1;
                    end else begin
                        irq_en_wr  = 1'b1;
                        start_fire = wrdata[0];
                        fifo_clr   = wrdata[2];
                    end
                end else if (word_idx == 32'(IDX_STATUS)) begin
                    ovf_clr = wrdata[3];
                end else begin
                    acc_err = 1'b1;                // RESULT is read-only
                end
            end else begin
                if (is_param) begin
                    rd_val = param_view[param_idx];
                end else if (word_idx == 32'(IDX_CTRL)) begin
                    rd_val[1] = irq_en_reg;
                end else if (word_idx == 32'(IDX_STATUS)) begin
                    rd_val = status_val;
                end else if (fifo_empty) begin
                    acc_err = 1'b1;
                end else begin
                    pop    = 1'b1;
                    rd_val = fifo_mem[rd_ptr_reg];
                end
            end
        end
    end

    // Clear beats a same-cycle push; a pop frees room for a push when full.
    logic push_ok, ovf_set;
    assign push_ok = ready && !fifo_clr && (!fifo_full || pop);
    assign ovf_set = ready && !fifo_clr && fifo_full && !pop;

    // ---------------- control / FIFO state ----------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ack_reg    <= 1'b0;
            err_reg    <= 1'b0;
            rddata_reg <= '0;
            start_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            irq_en_reg <= 1'b0;
            ovf_reg    <= 1'b0;
            irq_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            ack_reg    <= wr_req || rd_req;
            err_reg    <= acc_err;
            rddata_reg <= acc_err ? '0 : rd_val;
            start_reg  <= start_fire;
            // A new start wins over a same-cycle ready
            if (start_fire)  busy_reg <= 1'b1;
            else if (ready)  busy_reg <= 1'b0;
            if (irq_en_wr)   irq_en_reg <= wrdata[1];
            if (ovf_set)      ovf_reg <= 1'b1;
            else if (ovf_clr) ovf_reg <= 1'b0;
            irq_reg <= irq_en_reg && !fifo_empty;
            if (fifo_clr) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
                if (push_ok && !pop)      count_reg <= count_reg + 1'b1;
                else if (!push_ok && pop) count_reg <= count_reg - 1'b1;
            end
        end
    end

    // FIFO storage: plain array, no reset needed since pointers guard reads
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_reg] <= NN_result;
    end

    // ---------------- parameter registers ----------------
    genvar gi;
    generate
        for (gi = 0; gi < N_PARAM; gi++) begin : g_param
`ifdef NN_REGS_SHADOW_EN
            logic [DATA_W-1:0] shadow_reg, out_reg;
            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    shadow_reg <= '0;
                    out_reg    <= '0;
                end else begin
                    if (param_wr && param_idx == PIDX_W'(gi)) shadow_reg <= wrdata;
                    if (start_fire) out_reg <= shadow_reg;
                end
            end
            assign param_view[gi] = shadow_reg;
            assign param_out[gi]  = out_reg;
`else
            logic [DATA_W-1:0] value_reg;
            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l)                                     value_reg <= '0;
                else if (param_wr && param_idx == PIDX_W'(gi))  value_reg <= wrdata;
            end
            assign param_view[gi] = value_reg;
            assign param_out[gi]  = value_reg;
`endif
        end

        for (gi = 0; gi < N_IN; gi++) begin : g_ops
            assign ops[gi*DATA_W +: DATA_W] = param_out[gi];
        end
        for (gi = 0; gi < N_HID*N_IN; gi++) begin : g_wl1
            assign w_l1[gi*DATA_W +: DATA_W] = param_out[P_WL1 + gi];
        end
        for (gi = 0; gi < N_HID; gi++) begin : g_hid
            assign b_l1[gi*DATA_W +: DATA_W] = param_out[P_BL1 + gi];
            assign w_l2[gi*DATA_W +: DATA_W] = param_out[P_WL2 + gi];
        end
    endgenerate

    assign b_l2   = param_out[P_BL2];
    assign ack    = ack_reg;
    assign err    = err_reg;
    assign rddata = rddata_reg;
    assign start  = start_reg;
    assign irq    = irq_reg;

endmodule

// File: tb/tb_nn_param_regs.sv
module tb_nn_param_regs;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [31:0] A_OP0 = BASE + 32'h00;
    localparam logic [31:0] A_OP1 = BASE + 32'h04;
    localparam logic [31:0] A_CTL = BASE + 32'h08;
    localparam logic [31:0] A_STA = BASE + 32'h0C;
    localparam logic [31:0] A_RES = BASE + 32'h10;
    localparam logic [31:0] A_WL1 = BASE + 32'h14;
    localparam logic [31:0] A_WL2 = BASE + 32'h2C;
    localparam logic [31:0] A_BL2 = BASE + 32'h34;

`ifdef NN_REGS_SHADOW_EN
    localparam logic SHADOW = 1'b1;
`else
    localparam logic SHADOW = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_l = 1'b0;
    logic [31:0]  addr = '0;
    logic         wren = 1'b0, rden = 1'b0;
    logic [31:0]  wrdata = '0;
    logic         ack, err;
    logic [31:0]  rddata;
    logic [63:0]  ops;
    logic [127:0] w_l1;
    logic [63:0]  b_l1, w_l2;
    logic [31:0]  b_l2;
    logic         start;
    logic         ready = 1'b0;
    logic [31:0]  NN_result = '0;
    logic         irq;

    int total = 0;
    int passed = 0;

    logic [32:0] exp_q[$];     // {err, rddata} expected per access
    logic [31:0] fifo_model[$];

    nn_param_regs dut (
        .clk(clk), .rst_l(rst_l), .addr(addr), .wren(wren), .rden(rden),
        .wrdata(wrdata), .ack(ack), .err(err), .rddata(rddata),
        .ops(ops), .w_l1(w_l1), .b_l1(b_l1), .w_l2(w_l2), .b_l2(b_l2),
        .start(start), .ready(ready), .NN_result(NN_result), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    // One bus access; the expected response is queued at drive time and
    // popped when the DUT acknowledges.
    task automatic access(input string tag, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic e_err, input logic [31:0] e_data);
        logic [32:0] e;
        int n;
        @(negedge clk);
        wren = we; rden = !we; addr = a; wrdata = d;
        exp_q.push_back({e_err, e_data});
        @(negedge clk);
        wren = 1'b0; rden = 1'b0;
        n = 0;
        while (ack !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ack"}, 128'(ack), 128'(1'b1));
        e = exp_q.pop_front();
        chk({tag, "_err"}, 128'(err), 128'(e[32]));
        chk({tag, "_rd"}, 128'(rddata), 128'(e[31:0]));
        $display("access %s we=%0d addr=%08h wd=%08h -> err=%0d rd=%08h", tag, we, a, d, err, rddata);
    endtask

    task automatic pulse_ready(input logic [31:0] v);
        @(negedge clk);
        ready = 1'b1; NN_result = v;
        if (fifo_model.size() < 4) fifo_model.push_back(v);
        @(negedge clk);
        ready = 1'b0;
        $display("ready result=%08h model_count=%0d", v, fifo_model.size());
    endtask

    task automatic pop_result(input string tag);
        if (fifo_model.size() == 0) access(tag, 1'b0, A_RES, 0, 1'b1, 32'h0);
        else                        access(tag, 1'b0, A_RES, 0, 1'b0, fifo_model.pop_front());
    endtask

    initial begin
        // ---- 1: reset state ----
        repeat (3) @(negedge clk);
        chk("rst_ack", 128'(ack), 0);
        chk("rst_start", 128'(start), 0);
        chk("rst_irq", 128'(irq), 0);
        chk("rst_ops", 128'(ops), 0);
        chk("rst_wl1", w_l1, 0);
        rst_l = 1'b1;
        access("t1_status", 1'b0, A_STA, 0, 1'b0, 32'h0000_0002);
        @(negedge clk);
        chk("t1_ack_drop", 128'(ack), 0);

        // ---- 2: operand write/readback ----
        access("t2_wr_op0", 1'b1, A_OP0, 32'h1234_5678, 1'b0, 0);
        access("t2_wr_op1", 1'b1, A_OP1, 32'h8765_4321, 1'b0, 0);
        if (!SHADOW) chk("t2_ops", 128'(ops), 128'(64'h87654321_12345678));
        access("t2_rd_op0", 1'b0, A_OP0, 0, 1'b0, 32'h1234_5678);
        access("t2_rd_op1", 1'b0, A_OP1, 0, 1'b0, 32'h8765_4321);

        // ---- 3: start, result, irq ----
        access("t3_ctrl", 1'b1, A_CTL, 32'h3, 1'b0, 0);
        chk("t3_start_hi", 128'(start), 1);
        chk("t3_ops_run", 128'(ops), 128'(64'h87654321_12345678));
        @(negedge clk);
        chk("t3_start_lo", 128'(start), 0);
        access("t3_busy", 1'b0, A_STA, 0, 1'b0, 32'h0000_0003);
        access("t3_ctrl_rd", 1'b0, A_CTL, 0, 1'b0, 32'h0000_0002);
        pulse_ready(32'hDEAD_BEEF);
        @(negedge clk);
        chk("t3_irq_hi", 128'(irq), 1);
        access("t3_stat1", 1'b0, A_STA, 0, 1'b0, 32'h0000_0100);
        pop_result("t3_result");
        repeat (2) @(negedge clk);
        chk("t3_irq_lo", 128'(irq), 0);
        access("t3_stat0", 1'b0, A_STA, 0, 1'b0, 32'h0000_0002);

        // ---- 4: overflow and FIFO order ----
        for (int k = 1; k <= 5; k++) pulse_ready(32'(k));
        access("t4_full", 1'b0, A_STA, 0, 1'b0, 32'h0000_040C);
        for (int k = 0; k < 5; k++) pop_result("t4_pop");
        access("t4_ovf", 1'b0, A_STA, 0, 1'b0, 32'h0000_000A);
        access("t4_w1c", 1'b1, A_STA, 32'h8, 1'b0, 0);
        access("t4_clr", 1'b0, A_STA, 0, 1'b0, 32'h0000_0002);

        // ---- 5: rejected accesses ----
        access("t5_misalign", 1'b1, BASE + 32'h2, 32'hFFFF_FFFF, 1'b1, 0);
        chk("t5_ops_kept", 128'(ops), 128'(64'h87654321_12345678));
        access("t5_range", 1'b0, BASE + 32'h100, 0, 1'b1, 0);
        access("t5_last", 1'b0, A_BL2, 0, 1'b0, 0);
        access("t5_past", 1'b0, A_BL2 + 32'h4, 0, 1'b1, 0);
        access("t5_wr_res", 1'b1, A_RES, 32'h1, 1'b1, 0);
        access("t5_start", 1'b1, A_CTL, 32'h1, 1'b0, 0);
        access("t5_start2", 1'b1, A_CTL, 32'h1, 1'b1, 0);
        chk("t5_no_start", 128'(start), 0);
        access("t5_busy", 1'b0, A_STA, 0, 1'b0, 32'h0000_0003);

        // ---- 6: weight write while busy ----
        access("t6_wl1_busy", 1'b1, A_WL1, 32'hA5, !SHADOW, 0);
        chk("t6_wl1_frozen", w_l1, 0);
        pulse_ready(32'h99);
        access("t6_fifoclr", 1'b1, A_CTL, 32'h4, 1'b0, 0);
        fifo_model.delete();
        access("t6_empty", 1'b0, A_STA, 0, 1'b0, 32'h0000_0002);
        access("t6_wl1", 1'b1, A_WL1, 32'hA5, 1'b0, 0);
        access("t6_wl2", 1'b1, A_WL2, 32'h55, 1'b0, 0);
        access("t6_bl2", 1'b1, A_BL2, 32'h77, 1'b0, 0);
        access("t6_wl1_rd", 1'b0, A_WL1, 0, 1'b0, 32'hA5);
        chk("t6_wl1_pre", 128'(w_l1[31:0]), SHADOW ? 128'h0 : 128'hA5);
        access("t6_start", 1'b1, A_CTL, 32'h1, 1'b0, 0);
        chk("t6_wl1_post", 128'(w_l1[31:0]), 128'hA5);
        chk("t6_wl2_post", 128'(w_l2[31:0]), 128'h55);
        chk("t6_bl2_post", 128'(b_l2), 128'h77);
        chk("t6_bl1_post", 128'(b_l1), 0);
        pulse_ready(32'h1111);
        access("t6_final", 1'b0, A_STA, 0, 1'b0, 32'h0000_0100);
        pop_result("t6_pop");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
